// File: rtl/ext_int_ctrl_pkg.sv
// ext_int_ctrl_pkg: register map, source-ID width and FSM state type
// shared by the external interrupt controller files.
package Pu_ext_int;

   localparam int EIC_MAX_SRC = 32;
   localparam int EIC_ID_W    = $clog2(EIC_MAX_SRC);

   localparam logic [2:0] EIC_ENABLE  = 3'd0;
   localparam logic [2:0] EIC_EDGE    = 3'd1;
   localparam logic [2:0] EIC_PENDING = 3'd2;
   localparam logic [2:0] EIC_CLAIM   = 3'd3;
   localparam logic [2:0] EIC_EOI     = 3'd4;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} Eic_state;

endpackage

// File: rtl/ext_int_ctrl_if.sv
// ext_int_ctrl_if: scheduler request/ack handshake, register port and claim status.
interface ext_int_ctrl_if;

   logic        ext_input;
   logic        ext_input_ack;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;
   logic        claim_valid;
   logic [4:0]  claim_id;

   modport master (
      output ext_input, cfg_rdata, claim_valid, claim_id,
      input  ext_input_ack, cfg_we, cfg_addr, cfg_wdata
   );

   modport slave (
      input  ext_input, cfg_rdata, claim_valid, claim_id,
      output ext_input_ack, cfg_we, cfg_addr, cfg_wdata
   );

endinterface

// File: rtl/ext_int_ctrl_arbiter.sv
// ext_int_arbiter: picks the first eligible source searching upward from ptr+1,
// wrapping modulo N_SRC; ptr = N_SRC-1 gives plain lowest-index priority.
module ext_int_arbiter
   import Pu_ext_int::*;
#(
   parameter int N_SRC = 8
) (
   input  logic [N_SRC-1:0]    eligible,
   input  logic [EIC_ID_W-1:0] ptr,
   output logic                any,
   output logic [EIC_ID_W-1:0] id
);

   int               idx;
   logic [N_SRC-1:0] sh;

   always_comb begin
      any = |eligible;
      id  = '0;
      idx = 0;
      sh  = '0;
      // Descending scan so the candidate closest to ptr+1 is assigned last and wins.
      for (int k = N_SRC; k >= 1; k--) begin
         idx = (int'(ptr) + k) % N_SRC;
         sh  = eligible >> idx;
         if (sh[0]) id = EIC_ID_W'(idx);
      end
   end

endmodule

// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl: synchronises, latches, masks and arbitrates N_SRC interrupt pins onto one
// scheduler request. Define EXT_INT_RR_EN for round-robin instead of fixed priority.
module ext_int_ctrl
   import Pu_ext_int::*;
#(
   parameter int N_SRC       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq,
   ext_int_ctrl_if.master   bus
);

   logic [N_SRC-1:0]    sync_q [SYNC_STAGES];
   logic [N_SRC-1:0]    s, s_d, edge_v, enable_q, edge_q, pend_q, pend_eff, eligible, w1c, ack_clr;
   Eic_state            state_q, state_n;
   logic                ext_q, ext_n, ack_hit, any, eoi;
   logic [EIC_ID_W-1:0] cid_q, cid_n, win_id, ptr;
   logic                unused_ok;

   assign s        = sync_q[SYNC_STAGES-1];
   assign edge_v   = s & ~s_d;
   assign pend_eff = (pend_q & edge_q) | (s & ~edge_q);
   assign eligible = pend_eff & enable_q;
   assign eoi      = bus.cfg_we && bus.cfg_addr == EIC_EOI;
   assign w1c      = (bus.cfg_we && bus.cfg_addr == EIC_PENDING) ? bus.cfg_wdata[N_SRC-1:0] : '0;
   assign ack_clr  = ack_hit ? (N_SRC'(1) << cid_q) : '0;
   assign unused_ok = ^bus.cfg_wdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         s_d      <= '0;
         enable_q <= '0;
         edge_q   <= '0;
         pend_q   <= '0;
      end else begin
         sync_q[0] <= irq;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         s_d <= s;
         if (bus.cfg_we && bus.cfg_addr == EIC_ENABLE) enable_q <= bus.cfg_wdata[N_SRC-1:0];
         if (bus.cfg_we && bus.cfg_addr == EIC_EDGE) edge_q <= bus.cfg_wdata[N_SRC-1:0];
         // Only edge sources latch; a fresh edge overrides a clear landing in the same cycle.
         pend_q <= (pend_q & edge_q & ~(w1c | ack_clr)) | (edge_v & edge_q);
      end
   end

   ext_int_arbiter #(.N_SRC(N_SRC)) u_arb (
      .eligible(eligible),
      .ptr     (ptr),
      .any     (any),
      .id      (win_id)
   );

`ifdef EXT_INT_RR_EN
   logic [EIC_ID_W-1:0] ptr_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ptr_q <= EIC_ID_W'(N_SRC-1);
      else if (state_q == IDLE && any) ptr_q <= win_id;
   end
   assign ptr = ptr_q;
`else
   assign ptr = EIC_ID_W'(N_SRC-1);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ext_q   <= 1'b0;
         cid_q   <= '0;
      end else begin
         state_q <= state_n;
         ext_q   <= ext_n;
         cid_q   <= cid_n;
      end
   end

   always_comb begin
      state_n = state_q;
      ext_n   = ext_q;
      cid_n   = cid_q;
      ack_hit = 1'b0;
      case (state_q)
         IDLE: if (any) begin
            state_n = REQ;
            ext_n   = 1'b1;
            cid_n   = win_id;
         end
         REQ: if (bus.ext_input_ack) begin
            state_n = SERVICE;
            ext_n   = 1'b0;
            ack_hit = 1'b1;
         end
         SERVICE: if (eoi) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign bus.ext_input   = ext_q;
   assign bus.claim_valid = state_q != IDLE;
   assign bus.claim_id    = cid_q;
   assign bus.cfg_rdata   = bus.cfg_addr == EIC_ENABLE  ? 32'(enable_q) :
                            bus.cfg_addr == EIC_EDGE    ? 32'(edge_q) :
                            bus.cfg_addr == EIC_PENDING ? 32'(pend_eff) :
                            bus.cfg_addr == EIC_CLAIM   ? {bus.claim_valid, {(31-EIC_ID_W){1'b0}}, cid_q} :
                                                          32'd0;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// tb_ext_int_ctrl: directed scenarios plus randomized rounds checked against a
// set-based pending/arbitration model of the controller.
module tb_ext_int_ctrl;
   import Pu_ext_int::*;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] irq = '0;
   int           n_checks = 0;
   int           n_fail = 0;
   int           model_last = N - 1;

   ext_int_ctrl_if bus();

   ext_int_ctrl #(.N_SRC(N), .SYNC_STAGES(2)) dut (
      .clk  (clk),
      .reset(reset),
      .irq  (irq),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus.cfg_we = 1'b1;
      bus.cfg_addr = a;
      bus.cfg_wdata = d;
      tick();
      bus.cfg_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      bus.cfg_addr = a;
      #1;
      d = bus.cfg_rdata;
   endtask

   task automatic pulse(input logic [N-1:0] m);
      irq = m;
      tick();
      irq = '0;
   endtask

   // Expected winner: lowest eligible index, or first after the last grant when round-robin.
   function automatic int pick(input logic [N-1:0] elig, input int last);
      logic [N-1:0] t;
`ifdef EXT_INT_RR_EN
      for (int k = 1; k <= N; k++) begin
         t = elig >> ((last + k) % N);
         if (t[0]) return (last + k) % N;
      end
`else
      for (int j = 0; j < N; j++) begin
         t = elig >> j;
         if (t[0]) return j;
      end
`endif
      return -1;
   endfunction

   task automatic wait_req(input string tag);
      int n = 0;
      while (bus.ext_input !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      n_checks++;
      if (bus.ext_input !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_req: ext_input=%b required 1 within 12 cycles", tag, bus.ext_input);
      end
   endtask

   task automatic take(input int id, input string tag);
      wait_req(tag);
      n_checks++;
      if (bus.claim_id !== 5'(id)) begin
         n_fail++;
         $display("FAIL %s_id: claim_id=%0d required %0d", tag, bus.claim_id, id);
      end
      model_last = id;
      bus.ext_input_ack = 1'b1;
      tick();
      bus.ext_input_ack = 1'b0;
      n_checks++;
      if (bus.ext_input !== 1'b0 || bus.claim_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ack: ext_input=%b claim_valid=%b required 0/1", tag, bus.ext_input, bus.claim_valid);
      end
   endtask

   task automatic eoi(input string tag);
      wr(EIC_EOI, 32'hdead_beef);
      n_checks++;
      if (bus.claim_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_eoi: claim_valid=%b required 0", tag, bus.claim_valid);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      tick();
      tick();
      n_checks++;
      if (bus.ext_input !== 1'b0 || bus.claim_valid !== 1'b0 || bus.claim_id !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_out: ext=%b valid=%b id=%0d required 0", bus.ext_input, bus.claim_valid, bus.claim_id);
      end
      for (int a = 0; a < 4; a++) begin
         rd(3'(a), d);
         n_checks++;
         if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_reg%0d: read %h required 0", a, d);
         end
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_regs();
      logic [31:0] d;
      wr(EIC_ENABLE, 32'hffff_ffff);
      rd(EIC_ENABLE, d);
      n_checks++;
      if (d !== 32'h0000_00ff) begin
         n_fail++;
         $display("FAIL enable_rw: read %h required 000000ff", d);
      end
      wr(3'd5, 32'hffff_ffff);
      rd(3'd5, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL unmapped: read %h required 0", d);
      end
      wr(EIC_EDGE, 32'h0000_00f0);
      rd(EIC_EDGE, d);
      n_checks++;
      if (d !== 32'h0000_00f0) begin
         n_fail++;
         $display("FAIL edge_rw: read %h required 000000f0", d);
      end
      wr(EIC_EOI, 32'd0);
      bus.ext_input_ack = 1'b1;
      tick();
      bus.ext_input_ack = 1'b0;
      tick();
      n_checks++;
      if (bus.ext_input !== 1'b0 || bus.claim_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ignore: ext=%b valid=%b required 0/0", bus.ext_input, bus.claim_valid);
      end
   endtask

   task automatic test_latency();
      logic [31:0] d;
      wr(EIC_ENABLE, 32'h08);
      wr(EIC_EDGE, 32'h08);
      pulse(8'h08);
      tick();
      tick();
      n_checks++;
      if (bus.ext_input !== 1'b0) begin
         n_fail++;
         $display("FAIL lat_early: ext_input=%b at edge 3 required 0", bus.ext_input);
      end
      tick();
      n_checks++;
      if (bus.ext_input !== 1'b1 || bus.claim_id !== 5'd3) begin
         n_fail++;
         $display("FAIL lat_edge4: ext=%b id=%0d required 1/3", bus.ext_input, bus.claim_id);
      end
      model_last = 3;
      tick();
      tick();
      tick();
      n_checks++;
      if (bus.ext_input !== 1'b1) begin
         n_fail++;
         $display("FAIL lat_hold: ext_input=%b required 1", bus.ext_input);
      end
      bus.ext_input_ack = 1'b1;
      tick();
      bus.ext_input_ack = 1'b0;
      n_checks++;
      if (bus.ext_input !== 1'b0) begin
         n_fail++;
         $display("FAIL lat_ack: ext_input=%b required 0", bus.ext_input);
      end
      rd(EIC_CLAIM, d);
      n_checks++;
      if (d !== 32'h8000_0003) begin
         n_fail++;
         $display("FAIL lat_claim: read %h required 80000003", d);
      end
      rd(EIC_PENDING, d);
      n_checks++;
      if (d[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL lat_pend: bit3=%b required 0", d[3]);
      end
      eoi("lat");
   endtask

   task automatic test_priority();
      int first;
      wr(EIC_ENABLE, 32'hff);
      wr(EIC_EDGE, 32'hff);
      for (int r = 0; r < 2; r++) begin
         pulse(8'h24);
         repeat (4) tick();
         first = pick(8'h24, model_last);
         take(first, "prio_a");
         eoi("prio_a");
         take(pick(8'h24 & ~(8'(1) << first), model_last), "prio_b");
         eoi("prio_b");
      end
   endtask

   task automatic test_level();
      logic [31:0] d;
      wr(EIC_EDGE, 32'hfd);
      wr(EIC_ENABLE, 32'h02);
      irq[1] = 1'b1;
      take(1, "lvl");
      eoi("lvl");
      n_checks++;
      if (bus.ext_input !== 1'b0) begin
         n_fail++;
         $display("FAIL lvl_gap: ext_input=%b right after EOI required 0", bus.ext_input);
      end
      tick();
      n_checks++;
      if (bus.ext_input !== 1'b1 || bus.claim_id !== 5'd1) begin
         n_fail++;
         $display("FAIL lvl_rereq: ext=%b id=%0d required 1/1", bus.ext_input, bus.claim_id);
      end
      take(1, "lvl2");
      irq[1] = 1'b0;
      repeat (3) tick();
      eoi("lvl2");
      repeat (5) tick();
      n_checks++;
      if (bus.ext_input !== 1'b0 || bus.claim_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL lvl_drop: ext=%b valid=%b required 0/0", bus.ext_input, bus.claim_valid);
      end
      rd(EIC_PENDING, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL lvl_pend: read %h required 0", d);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      wr(EIC_EDGE, 32'hff);
      wr(EIC_ENABLE, 32'h10);
      pulse(8'h10);
      take(4, "b2b");
      pulse(8'h10);
      repeat (4) tick();
      rd(EIC_PENDING, d);
      n_checks++;
      if (d !== 32'h10) begin
         n_fail++;
         $display("FAIL b2b_pend: read %h required 00000010", d);
      end
      eoi("b2b");
      tick();
      n_checks++;
      if (bus.ext_input !== 1'b1 || bus.claim_id !== 5'd4) begin
         n_fail++;
         $display("FAIL b2b_rereq: ext=%b id=%0d required 1/4", bus.ext_input, bus.claim_id);
      end
      take(4, "b2b2");
      rd(EIC_PENDING, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL b2b_clr: read %h required 0", d);
      end
      eoi("b2b2");
   endtask

   task automatic test_enable_w1c();
      logic [31:0] d;
      wr(EIC_ENABLE, 32'h40);
      pulse(8'h40);
      wait_req("dis");
      wr(EIC_ENABLE, 32'h00);
      repeat (3) tick();
      n_checks++;
      if (bus.ext_input !== 1'b1 || bus.claim_id !== 5'd6) begin
         n_fail++;
         $display("FAIL dis_hold: ext=%b id=%0d required 1/6", bus.ext_input, bus.claim_id);
      end
      take(6, "dis");
      eoi("dis");
      // Pulse sampled at edge k+1 latches at edge k+3, the same edge that samples the W1C.
      irq[0] = 1'b1;
      tick();
      irq[0] = 1'b0;
      tick();
      bus.cfg_we = 1'b1;
      bus.cfg_addr = EIC_PENDING;
      bus.cfg_wdata = 32'h1;
      tick();
      bus.cfg_we = 1'b0;
      rd(EIC_PENDING, d);
      n_checks++;
      if (d[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL w1c_race: bit0=%b required 1", d[0]);
      end
      wr(EIC_PENDING, 32'h1);
      rd(EIC_PENDING, d);
      n_checks++;
      if (d[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL w1c_clear: bit0=%b required 0", d[0]);
      end
   endtask

   task automatic test_random();
      logic [31:0] d;
      logic [N-1:0] en, pend;
      int id;
      wr(EIC_EDGE, 32'hff);
      for (int r = 0; r < 20; r++) begin
         en = N'($urandom_range(0, 255));
         pend = N'($urandom_range(1, 255));
         wr(EIC_ENABLE, 32'(en));
         pulse(pend);
         repeat (4) tick();
         rd(EIC_PENDING, d);
         n_checks++;
         if (d !== 32'(pend)) begin
            n_fail++;
            $display("FAIL rnd%0d_pend: read %h required %h", r, d, 32'(pend));
         end
         while ((pend & en) != '0) begin
            id = pick(pend & en, model_last);
            take(id, "rnd");
            pend &= ~(N'(1) << id);
            rd(EIC_PENDING, d);
            n_checks++;
            if (d !== 32'(pend)) begin
               n_fail++;
               $display("FAIL rnd%0d_left: read %h required %h", r, d, 32'(pend));
            end
            eoi("rnd");
         end
         repeat (3) tick();
         n_checks++;
         if (bus.ext_input !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd%0d_quiet: ext_input=%b required 0", r, bus.ext_input);
         end
         wr(EIC_PENDING, 32'hff);
         rd(EIC_PENDING, d);
         n_checks++;
         if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL rnd%0d_w1c: read %h required 0", r, d);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      wr(EIC_ENABLE, 32'h08);
      pulse(8'h08);
      wait_req("rst");
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.ext_input !== 1'b0 || bus.claim_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_async: ext=%b valid=%b required 0/0", bus.ext_input, bus.claim_valid);
      end
      rd(EIC_ENABLE, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_enable: read %h required 0", d);
      end
      rd(EIC_EDGE, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_edge: read %h required 0", d);
      end
      tick();
      reset = 1'b1;
      model_last = N - 1;
      repeat (8) tick();
      n_checks++;
      if (bus.ext_input !== 1'b0 || bus.claim_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_quiet: ext=%b valid=%b required 0/0", bus.ext_input, bus.claim_valid);
      end
   endtask

   initial begin
      bus.ext_input_ack = 1'b0;
      bus.cfg_we = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_wdata = '0;
      test_reset();
      test_regs();
      test_latency();
      test_priority();
      test_level();
      test_back_to_back();
      test_enable_w1c();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
